fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end. Replaces the free-running `next_pc+4` fetch loop.
- Issues word requests to the synchronous instruction memory with configurable read latency, tracks in-flight requests, and buffers returned instructions in a FIFO.
- Presents {pc, inst} packets to decode over a valid/ready handshake.
- Supports stall (back-pressure) and PC redirect with flush of wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (bits [1:0] must be 0).
- MEM_LATENCY, 1, cycles from imem_req to imem_rdata valid (legal range 1..4).
- FIFO_DEPTH, 4, fetch buffer entries (power of two, >= 2; full throughput requires >= MEM_LATENCY+1).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  30  word address (pc>>2) of the request.
- imem_rdata  input  32  instruction word, valid exactly MEM_LATENCY cycles after its request.
- redirect_valid  input  1  PC redirect (branch/jump) this cycle.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- out_valid  output  1  packet available to decode.
- out_ready  input  1  decode accepts packet.
- out_pc  output  32  byte PC of the presented instruction.
- out_inst  output  32  presented instruction word.
- fetch_count  output  32  number of completed out handshakes since reset (wraps).

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; in-flight pipe cleared; epoch=0; fetch_count=0.
  - Outputs: imem_req=0, out_valid=0, out_pc=0, out_inst=0.
  - redirect_valid is ignored while rst=1.
  - Reset mid-operation discards all in-flight and buffered entries.
- Issue rule (combinational):
  - imem_req = !rst && !redirect_valid && (fifo_count + inflight_count - pop) < FIFO_DEPTH, where pop = out_valid && out_ready.
  - imem_addr = fetch_pc[31:2].
  - On issue, fetch_pc += 4 at posedge; wraps 32'hFFFF_FFFC -> 0.
- In-flight tracking:
  - MEM_LATENCY-stage shift register of {valid, epoch, pc}.
  - The stage emerging at cycle t+MEM_LATENCY pairs with imem_rdata.
  - If its epoch equals the current epoch, {pc, imem_rdata} is pushed into the FIFO at that posedge; otherwise it is dropped silently.
- Output:
  - out_valid = FIFO non-empty. No bypass.
  - Request issued in cycle t gives out_valid no earlier than cycle t+MEM_LATENCY+1.
  - First out_valid after reset release is in cycle MEM_LATENCY+1, counting the first rst-low cycle as cycle 0.
  - While out_valid && !out_ready: out_pc/out_inst hold stable and out_valid stays 1.
- Throughput: with out_ready=1 and FIFO_DEPTH >= MEM_LATENCY+1, one packet per cycle in steady state.
- Redirect (redirect_valid=1 at posedge):
  - FIFO flushed; epoch toggles; fetch_pc = {redirect_pc[31:2],2'b00}; imem_req=0 in the redirect cycle.
  - Fetch at the target is issued the next cycle.
  - Old-epoch data returning later is dropped.
  - Redirect + out handshake in the same cycle: the handshake completes and fetch_count increments, then the flush applies.
  - Redirect + FIFO push in the same cycle: the pushed entry is discarded.
  - Back-to-back redirects: the last one wins.
- FIFO:
  - Full: push never occurs, guaranteed by the credit rule. Assertion: push && full is an error.
  - Empty: pop never occurs because out_valid=0.
  - Simultaneous push/pop when full or empty is handled (count unchanged).
- fetch_count: +1 per handshake, wraps at 2^32.
- Elaboration-time check: MEM_LATENCY in 1..4, FIFO_DEPTH a power of two and >= 2.

Decomposition:
- types.svh package additions:
  - fetchPktT = struct {rvwordT pc; rvwordT inst;}.
  - inflightT = struct {logic valid; logic epoch; rvwordT pc;}.
  - Constant INST_BYTES=4.
- Sub-module fetch_fifo:
  - Parameter DEPTH; synchronous FIFO of fetchPktT with push/pop/flush, count, full/empty.
  - Flush has priority over push; pop-then-flush is legal.
- fetch_unit holds the PC, epoch, credit logic and in-flight shift register.

Test Plan:
- Reset/stream: RESET_PC=0, MEM_LATENCY=1, out_ready=1, memory loaded with word i = 0x1000+i -> out_valid first in cycle 2; out_pc 0,4,8,... one per cycle; out_inst 0x1000,0x1001,...
- Stall: assert out_ready=0 from cycle 3 for 10 cycles -> imem_req drops once 4 entries (buffered plus in-flight) are held; out_pc/out_inst stay stable throughout; on release, no PC is skipped or duplicated.
- Redirect with in-flight data: MEM_LATENCY=3, redirect_pc=0x40 at cycle 6 -> no out_pc in 0x18..0x2C appears after cycle 6; next packet is out_pc=0x40 in cycle 11.
- Redirect with handshake: redirect coincides with a pop of pc 0x8 -> fetch_count increments; the next out_pc is the redirect target; unaligned redirect_pc 0x43 fetches from 0x40.
- Wrap: RESET_PC=0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- Reset mid-stream: rst=1 for 1 cycle while the FIFO holds 3 entries -> out_valid=0 and fetch_count=0 the next cycle; the stream restarts at RESET_PC with no stale packet.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction-fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  typedef logic [31:0] rvwordT;

  localparam int INST_BYTES = 4;

  typedef struct packed {
    rvwordT pc;
    rvwordT inst;
  } fetchPktT;

  typedef struct packed {
    logic   valid;
    logic   epoch;
    rvwordT pc;
  } inflightT;

  function automatic logic is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous fetch-packet buffer with push/pop/flush; flush wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [31:0]            i_push_pc,
  input  logic [31:0]            i_push_inst,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic [31:0]            o_head_pc,
  output logic [31:0]            o_head_inst
);

  localparam int AW = $clog2(DEPTH);

  fetchPktT        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A pop frees the head slot before the write lands, so push+pop on a full buffer is safe.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && !i_flush && (!w_full || w_pop);

  assign o_head_pc   = r_mem[r_rd_ptr].pc;
  assign o_head_inst = r_mem[r_rd_ptr].inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr].pc   <= i_push_pc;
      r_mem[r_wr_ptr].inst <= i_push_inst;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && w_full && !w_pop));

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Credit-based instruction fetch with in-flight tracking and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_count
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + MEM_LATENCY) + 2;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("fetch_unit: MEM_LATENCY must be in 1..4");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("fetch_unit: FIFO_DEPTH must be a power of two >= 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end

  rvwordT          r_fetch_pc;
  logic            r_epoch;
  inflightT        r_pipe [MEM_LATENCY];
  rvwordT          r_fetch_count;

  logic [FCW-1:0]  w_fifo_count;
  logic            w_fifo_empty;
  rvwordT          w_head_pc;
  rvwordT          w_head_inst;
  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_used;
  logic            w_pop;
  logic            w_push;
  inflightT        w_emerge;
  rvwordT          w_redirect_target;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_pipe[i].valid);
    end
  end

  // Every buffered or in-flight word holds a FIFO slot, so a returning word always fits.
  assign w_pop    = !w_fifo_empty && out_ready;
  assign w_used   = CW'(w_fifo_count) + w_inflight - CW'(w_pop);
  assign imem_req = !rst && !redirect_valid && (w_used < CW'(FIFO_DEPTH));
  assign imem_addr = r_fetch_pc[31:2];

  assign w_emerge          = r_pipe[MEM_LATENCY-1];
  assign w_push            = w_emerge.valid && (w_emerge.epoch == r_epoch) && !redirect_valid;
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_target;
      r_epoch    <= ~r_epoch;
    end else if (imem_req) begin
      r_fetch_pc <= r_fetch_pc + rvwordT'(INST_BYTES);
    end
  end

  // Killing stage valids on redirect keeps back-to-back redirects from aliasing the 1-bit epoch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= imem_req;
      r_pipe[0].epoch <= r_epoch;
      r_pipe[0].pc    <= r_fetch_pc;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        if (redirect_valid) r_pipe[i].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_pc   (w_emerge.pc),
    .i_push_inst (imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_head_pc   (w_head_pc),
    .o_head_inst (w_head_inst)
  );

  assign out_valid   = !w_fifo_empty;
  assign out_pc      = out_valid ? w_head_pc   : '0;
  assign out_inst    = out_valid ? w_head_inst : '0;
  assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed scoreboard bench for fetch_unit (MEM_LATENCY=2, FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MEM_LATENCY (L),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory image: word w holds 0x1000 + w, returned L cycles after the request.
  logic [29:0] m_addr [L];
  always @(posedge clk) begin
    m_addr[0] <= imem_addr;
    for (int k = 1; k < L; k++) m_addr[k] <= m_addr[k-1];
  end
  assign imem_rdata = 32'h1000 + {2'b00, m_addr[L-1]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    pkt_t p;
    for (int i = 0; i < n; i++) begin
      p.pc   = base + 32'(4 * i);
      p.inst = 32'h1000 + (p.pc >> 2);
      exp_q.push_back(p);
    end
  endtask

  // Monitor: compares every completed handshake and checks stall stability.
  initial begin
    logic        m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    pkt_t        e;
    m_hold = 1'b0;
    m_pc   = '0;
    m_inst = '0;
    forever begin
      @(negedge clk);
      if (m_hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'h1);
        chk("hold_pc", out_pc, m_pc);
        chk("hold_inst", out_inst, m_inst);
      end
      m_hold = (rst === 1'b0) && out_valid && !out_ready && !redirect_valid;
      m_pc   = out_pc;
      m_inst = out_inst;
      if ((rst === 1'b0) && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h inst %h expected no packet (cycle %0d)",
                   out_pc, out_inst, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", out_pc, e.pc);
          chk("sb_inst", out_inst, e.inst);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0abc;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_count", fetch_count, 32'h0);

    @(posedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    cyc            = 0;
    push_seq(32'h0, 32);
    @(negedge clk);
    chk("c0_req", {31'b0, imem_req}, 32'h1);
    chk("c0_addr", {2'b00, imem_addr}, 32'h0);
    chk("c0_valid", {31'b0, out_valid}, 32'h0);
    goto(1); @(negedge clk); chk("c1_valid", {31'b0, out_valid}, 32'h0);
    goto(2); @(negedge clk); chk("c2_valid", {31'b0, out_valid}, 32'h0);
    goto(3); @(negedge clk);
    chk("first_valid", {31'b0, out_valid}, 32'h1);
    chk("first_pc", out_pc, 32'h0);

    // Stall: decode stops accepting with pc 0xC at the head.
    goto(6); out_ready = 1'b0; @(negedge clk);
    chk("stall_req_c6", {31'b0, imem_req}, 32'h1);
    goto(7); @(negedge clk);
    chk("credit_stop_c7", {31'b0, imem_req}, 32'h0);
    goto(12); @(negedge clk);
    chk("credit_stop_c12", {31'b0, imem_req}, 32'h0);
    chk("stall_pc", out_pc, 32'h0000_000C);
    chk("stall_inst", out_inst, 32'h0000_1003);
    goto(16); out_ready = 1'b1;

    // Unaligned redirect coinciding with the handshake of pc 0x24.
    goto(22); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; @(negedge clk);
    chk("redir_req", {31'b0, imem_req}, 32'h0);
    goto(23); redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_q.delete(); push_seq(32'h0000_0200, 16);
    @(negedge clk);
    chk("redir_count", fetch_count, 32'd10);
    chk("redir_req_next", {31'b0, imem_req}, 32'h1);
    chk("redir_addr", {2'b00, imem_addr}, 32'h0000_0080);
    chk("redir_valid_c23", {31'b0, out_valid}, 32'h0);
    goto(25); @(negedge clk); chk("redir_valid_c25", {31'b0, out_valid}, 32'h0);
    goto(26); @(negedge clk);
    chk("redir_valid_c26", {31'b0, out_valid}, 32'h1);
    chk("redir_pc", out_pc, 32'h0000_0200);
    chk("redir_inst", out_inst, 32'h0000_1080);

    // PC wrap across the top of the address space.
    goto(30); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    goto(31); redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_q.delete(); push_seq(32'hFFFF_FFF8, 8);
    @(negedge clk);
    chk("wrap_count", fetch_count, 32'd15);
    goto(34); @(negedge clk);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    chk("wrap_inst0", out_inst, 32'h4000_0FFE);
    goto(36); @(negedge clk);
    chk("wrap_pc2", out_pc, 32'h0000_0000);
    chk("wrap_inst2", out_inst, 32'h0000_1000);

    // Back-to-back redirects: the second target wins.
    goto(38); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    goto(39); redirect_pc = 32'h0000_0403; @(negedge clk);
    chk("b2b_count", fetch_count, 32'd20);
    chk("b2b_valid", {31'b0, out_valid}, 32'h0);
    goto(40); redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_q.delete(); push_seq(32'h0000_0400, 8);
    @(negedge clk);
    chk("b2b_addr", {2'b00, imem_addr}, 32'h0000_0100);
    goto(42); @(negedge clk); chk("b2b_valid_c42", {31'b0, out_valid}, 32'h0);
    goto(43); out_ready = 1'b0; @(negedge clk);
    chk("b2b_valid_c43", {31'b0, out_valid}, 32'h1);
    chk("b2b_pc", out_pc, 32'h0000_0400);
    chk("b2b_inst", out_inst, 32'h0000_1100);

    // Reset while three packets are buffered.
    goto(45); rst = 1'b1; @(negedge clk);
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    goto(46); rst = 1'b0; out_ready = 1'b1;
    exp_q.delete(); push_seq(32'h0, 8);
    @(negedge clk);
    chk("post_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("post_rst_count", fetch_count, 32'h0);
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", {2'b00, imem_addr}, 32'h0);
    goto(48); @(negedge clk); chk("restart_valid_c48", {31'b0, out_valid}, 32'h0);
    goto(49); @(negedge clk);
    chk("restart_valid_c49", {31'b0, out_valid}, 32'h1);
    chk("restart_pc", out_pc, 32'h0);
    goto(54); @(negedge clk);
    chk("final_count", fetch_count, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
